// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a registered-output FIFO and streams its words as fixed-length bursts with idle gaps.
// Define FIFO_BURST_PARITY_EN to add the even-parity output m_parity.
module fifo_burst_reader #(
   parameter int WIDTH = 16,
   parameter int BURST_LEN = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic [WIDTH-1:0] fifo_data_out,
   input  logic             fifo_empty,
   output logic             fifo_read,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last,
   output logic [15:0]      burst_cnt
`ifdef FIFO_BURST_PARITY_EN
   ,
   output logic             m_parity
`endif
);
   localparam int BW = $clog2(BURST_LEN + 1);
   localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
`ifdef FIFO_BURST_PARITY_EN
   localparam int EW = WIDTH + 1;
`else
   localparam int EW = WIDTH;
`endif
   typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;
   state_t state, state_nxt;
   logic [1:0] occ;
   logic rd_pending, pop, last;
   logic [EW-1:0] din, buf0, buf1;
   logic [BW-1:0] beat_cnt, beat_nxt;
   logic [GW-1:0] gap_cnt, gap_nxt;
   logic [15:0] burst_nxt;

`ifdef FIFO_BURST_PARITY_EN
   assign din = {^fifo_data_out, fifo_data_out};
   assign m_parity = buf0[WIDTH];
`else
   assign din = fifo_data_out;
`endif
   // rd_pending covers the FIFO's one-cycle-late empty flag and guarantees a free slot on capture
   assign fifo_read = !fifo_empty && !rd_pending && occ < 2'd2;
   assign m_data = buf0[WIDTH-1:0];
   assign pop = m_valid && m_ready;

   always_comb begin
      state_nxt = state;
      beat_nxt = beat_cnt;
      gap_nxt = gap_cnt;
      burst_nxt = burst_cnt;
      m_valid = state != GAP && occ != 2'd0;
      last = beat_cnt == BW'(BURST_LEN - 1);
      m_last = m_valid && last;
      if (state == GAP) begin
         gap_nxt = gap_cnt == GW'(GAP_CYCLES - 1) ? '0 : gap_cnt + 1'b1;
         state_nxt = gap_cnt == GW'(GAP_CYCLES - 1) ? IDLE : GAP;
      end else if (pop) begin
         beat_nxt = last ? '0 : beat_cnt + 1'b1;
         burst_nxt = last ? burst_cnt + 16'd1 : burst_cnt;
         state_nxt = !last ? BURST : (GAP_CYCLES > 0 ? GAP : IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state <= IDLE;
         beat_cnt <= '0;
         gap_cnt <= '0;
         burst_cnt <= '0;
      end else begin
         state <= state_nxt;
         beat_cnt <= beat_nxt;
         gap_cnt <= gap_nxt;
         burst_cnt <= burst_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         occ <= '0;
         rd_pending <= 1'b0;
         buf0 <= '0;
         buf1 <= '0;
      end else begin
         rd_pending <= fifo_read;
         occ <= occ + {1'b0, rd_pending} - {1'b0, pop};
         if (pop)
            buf0 <= (occ == 2'd2 || !rd_pending) ? buf1 : din;
         else if (rd_pending && occ == 2'd0)
            buf0 <= din;
         if (rd_pending && (pop ? occ == 2'd2 : occ == 2'd1))
            buf1 <= din;
      end
   end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: drives fifo_burst_reader from a behavioural FIFO and scores the stream against a
// word-count model of the burst, gap and read-latency rules.
module tb_fifo_burst_reader;
   localparam int W = 16;
   localparam int BL = 4;
   localparam int GC = 2;

   logic clk = 1'b0;
   logic rst_ = 1'b1;
   logic [W-1:0] fifo_data_out = '0;
   logic fifo_empty = 1'b1;
   logic fifo_read;
   logic [W-1:0] m_data;
   logic m_valid;
   logic m_ready = 1'b0;
   logic m_last;
   logic [15:0] burst_cnt;
`ifdef FIFO_BURST_PARITY_EN
   logic m_parity;
`endif

   fifo_burst_reader #(.WIDTH(W), .BURST_LEN(BL), .GAP_CYCLES(GC)) dut (
      .clk(clk), .rst_(rst_), .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
      .fifo_read(fifo_read), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_last(m_last), .burst_cnt(burst_cnt)
`ifdef FIFO_BURST_PARITY_EN
      , .m_parity(m_parity)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [W-1:0] fq[$];
   logic [W-1:0] rq[$];
   int avail, pend, beats, gap_left, bursts, nreads;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      fq.delete();
      rq.delete();
      avail = 0; pend = 0; beats = 0; gap_left = 0; bursts = 0;
      fifo_data_out = '0;
      fifo_empty = 1'b1;
   endtask

   task automatic push(input logic [W-1:0] w);
      fq.push_back(w);
      rq.push_back(w);
   endtask

   // starts just after a negedge, ends on the next negedge
   task automatic cycle();
      logic fr, tr, exp_v;
      #1;
      exp_v = gap_left == 0 && avail > 0;
      check("m_valid", m_valid, exp_v);
      check("fifo_read", fifo_read, !fifo_empty && pend == 0 && avail < 2);
      check("burst_cnt", burst_cnt, bursts & 32'hFFFF);
      if (exp_v && rq.size() > 0) begin
         check("m_data", m_data, rq[0]);
         check("m_last", m_last, (beats % BL) == BL - 1);
`ifdef FIFO_BURST_PARITY_EN
         check("m_parity", m_parity, ^rq[0]);
`endif
      end else
         check("m_last_idle", m_last, 0);
      fr = fifo_read;
      tr = exp_v && m_ready;
      @(posedge clk);
      #1;
      if (fr) begin
         nreads++;
         check("underflow", fq.size() > 0, 1);
      end
      fifo_empty = fq.size() == 0;
      if (fr && fq.size() > 0) fifo_data_out = fq.pop_front();
      avail += pend;
      pend = fr;
      if (gap_left > 0) gap_left--;
      if (tr) begin
         avail--;
         if (rq.size() > 0) void'(rq.pop_front());
         if ((beats % BL) == BL - 1) begin
            bursts++;
            gap_left = GC;
         end
         beats++;
      end
      @(negedge clk);
   endtask

   // asserts reset between edges so the outputs must clear without a clock
   task automatic do_reset();
      rst_ = 1'b0;
      model_reset();
      #1;
      check("rst_fifo_read", fifo_read, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_last", m_last, 0);
      check("rst_m_data", m_data, 0);
      check("rst_burst_cnt", burst_cnt, 0);
`ifdef FIFO_BURST_PARITY_EN
      check("rst_m_parity", m_parity, 0);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_ = 1'b1;
   endtask

   initial begin
      #2;
      do_reset();
      repeat (10) cycle();
      check("idle_burst_cnt", burst_cnt, 0);

      do_reset();
      m_ready = 1'b1;
      for (int i = 1; i <= 8; i++) push(W'(i));
      repeat (40) cycle();
      check("two_bursts", burst_cnt, 2);
      check("eight_drained", rq.size(), 0);

      do_reset();
      for (int i = 1; i <= 3; i++) push(W'(i));
      repeat (20) cycle();
      check("partial_burst_cnt", burst_cnt, 0);
      check("partial_sent", rq.size(), 0);
      check("partial_valid_low", m_valid, 0);
      push(16'h0004);
      repeat (10) cycle();
      check("partial_closed", burst_cnt, 1);

      do_reset();
      m_ready = 1'b0;
      for (int i = 1; i <= 6; i++) push(W'(i));
      nreads = 0;
      repeat (20) cycle();
      check("stall_reads", nreads, 2);
      check("stall_head", m_data, 16'h0001);
      m_ready = 1'b1;
      repeat (40) cycle();
      check("stall_drained", rq.size(), 0);
      check("stall_fifo_empty", fq.size(), 0);

      do_reset();
      for (int i = 0; i < 8; i++) push(W'(16'h0010 + i));
      begin
         bit hit = 1'b0;
         for (int n = 0; n < 60 && !hit; n++) begin
            cycle();
            hit = beats == 2 && pend == 1;
         end
         check("midrst_setup", hit, 1);
      end
      do_reset();
      for (int i = 1; i <= 4; i++) push(W'(i));
      repeat (20) cycle();
      check("midrst_burst", burst_cnt, 1);

      do_reset();
      for (int n = 0; n < 3000; n++) begin
         m_ready = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 3) == 0) push(W'($urandom));
         cycle();
      end
      m_ready = 1'b1;
      for (int n = 0; n < 4000 && rq.size() > 0; n++) cycle();
      check("random_drained", rq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
